// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU packet types, command/response encodings and lane count
package alu_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_ADD     = 2'd1,
    CMD_SUB     = 2'd2,
    CMD_INVALID = 2'd3
  } command_t;

  typedef enum logic [1:0] {
    RESP_NONE     = 2'd0,
    RESP_SUCCESS  = 2'd1,
    RESP_INVALID  = 2'd2,
    RESP_OVERFLOW = 2'd3
  } response_t;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    command_t    command;
  } input_packet_t;

  typedef struct packed {
    logic [31:0] data;
    response_t   response;
  } output_packet_t;

  localparam input_packet_t NOP_PACKET = '{data1: 32'd0, data2: 32'd0, command: CMD_NOP};

endpackage

// File: rtl/request_fifo.sv
// rtl/request_fifo.sv - synchronous FIFO with async reset and wrap-bit pointers
module request_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // The extra MSB distinguishes full from empty when the address bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/alu_request_dispatcher.sv
// rtl/alu_request_dispatcher.sv - per-lane request queues feeding the ALU under credit control
module alu_request_dispatcher
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic           [NUM_LANES-1:0]      req_valid,
  output logic           [NUM_LANES-1:0]      req_ready,
  input  input_packet_t  [NUM_LANES-1:0]      req_packet,
  output input_packet_t  [NUM_LANES-1:0]      input_packet,
  input  output_packet_t [NUM_LANES-1:0]      output_packet,
  output logic           [NUM_LANES-1:0][2:0] credit_count,
  output logic           [NUM_LANES-1:0]      credit_error
);

  localparam logic [2:0] MAX_CREDITS = 3'(CREDITS);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic          w_full;
    logic          w_empty;
    logic          w_issue;
    logic          w_drop;
    logic          w_return;
    input_packet_t w_head;
    input_packet_t r_input_packet;
    logic [2:0]    r_credit;
    logic          r_error;
    logic [31:0]   unused_result_data;

    request_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(input_packet_t))
    ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_push      (req_valid[g] && req_ready[g]),
      .i_push_data (req_packet[g]),
      .i_pop       (w_issue || w_drop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
    );

    assign req_ready[g]       = !w_full && !reset;
    assign w_issue            = !w_empty && (w_head.command != CMD_NOP) && (r_credit != 3'd0);
    assign w_drop             = !w_empty && (w_head.command == CMD_NOP);
    assign w_return           = (output_packet[g].response != RESP_NONE);
    assign unused_result_data = output_packet[g].data;

    // A return and an issue on the same edge cancel; a surplus return is flagged, not counted.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_input_packet <= NOP_PACKET;
        r_credit       <= MAX_CREDITS;
        r_error        <= 1'b0;
      end else begin
        r_input_packet <= w_issue ? w_head : NOP_PACKET;
        if (w_issue && !w_return) begin
          r_credit <= r_credit - 3'd1;
        end else if (w_return && !w_issue) begin
          if (r_credit == MAX_CREDITS) r_error  <= 1'b1;
          else                         r_credit <= r_credit + 3'd1;
        end
      end
    end

    assign input_packet[g] = r_input_packet;
    assign credit_count[g] = r_credit;
    assign credit_error[g] = r_error;
  end

endmodule

// File: tb/tb_alu_request_dispatcher.sv
// tb/tb_alu_request_dispatcher.sv - directed self-checking bench for alu_request_dispatcher
module tb_alu_request_dispatcher;
  import alu_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [3:0]                req_valid;
  logic [3:0]                req_ready;
  input_packet_t  [3:0]      req_packet;
  input_packet_t  [3:0]      input_packet;
  output_packet_t [3:0]      output_packet;
  logic [3:0][2:0]           credit_count;
  logic [3:0]                credit_error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  input_packet_t exp_q[$];
  input_packet_t exp_p;
  int            got;
  int            owed;
  int            more;

  alu_request_dispatcher #(.FIFO_DEPTH(4), .CREDITS(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_packet    (req_packet),
    .input_packet  (input_packet),
    .output_packet (output_packet),
    .credit_count  (credit_count),
    .credit_error  (credit_error)
  );

  always #5 clock = ~clock;

  function automatic input_packet_t mk(input logic [31:0] a, input logic [31:0] b, input command_t c);
    input_packet_t p;
    p.data1   = a;
    p.data2   = b;
    p.command = c;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pkt(input string tag, input input_packet_t obs, input input_packet_t exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input logic [1:0] lane, input input_packet_t p);
    req_valid       = '0;
    req_valid[lane] = 1'b1;
    req_packet[lane] = p;
    tick();
    req_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_packet = '0;
    output_packet = '0;
    repeat (3) @(negedge clock);

    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_credits", 32'(credit_count), 32'h492);
    check_pkt("rst_pkt0", input_packet[0], NOP_PACKET);
    check("rst_err", 32'(credit_error), 32'h0);
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(req_ready), 32'hF);

    // single issue on lane 1
    push(2'd1, mk(32'h5, 32'h3, CMD_ADD));
    check_pkt("no_bypass", input_packet[1], NOP_PACKET);
    check("no_bypass_cr", 32'(credit_count[1]), 32'd2);
    tick();
    check_pkt("single_issue", input_packet[1], mk(32'h5, 32'h3, CMD_ADD));
    check("single_cr", 32'(credit_count[1]), 32'd1);
    tick();
    check_pkt("single_idle", input_packet[1], NOP_PACKET);
    output_packet[1].response = RESP_SUCCESS;
    tick();
    output_packet = '0;
    check("single_ret", 32'(credit_count[1]), 32'd2);

    // credit stall on lane 1
    push(2'd1, mk(32'h10, 32'h20, CMD_ADD));
    check_pkt("stall_e1", input_packet[1], NOP_PACKET);
    push(2'd1, mk(32'h11, 32'h21, CMD_ADD));
    check_pkt("stall_e2", input_packet[1], mk(32'h10, 32'h20, CMD_ADD));
    push(2'd1, mk(32'h12, 32'h22, CMD_ADD));
    check_pkt("stall_e3", input_packet[1], mk(32'h11, 32'h21, CMD_ADD));
    check("stall_cr0", 32'(credit_count[1]), 32'd0);
    push(2'd1, mk(32'h13, 32'h23, CMD_ADD));
    check_pkt("stall_e4", input_packet[1], NOP_PACKET);
    tick();
    check_pkt("stall_e5", input_packet[1], NOP_PACKET);
    check("stall_cr0b", 32'(credit_count[1]), 32'd0);
    output_packet[1].response = RESP_SUCCESS;
    tick();
    output_packet = '0;
    check("stall_ret_cr", 32'(credit_count[1]), 32'd1);
    check_pkt("stall_ret_pkt", input_packet[1], NOP_PACKET);
    tick();
    check_pkt("stall_third", input_packet[1], mk(32'h12, 32'h22, CMD_ADD));
    check("stall_third_cr", 32'(credit_count[1]), 32'd0);
    output_packet[1].response = RESP_SUCCESS;
    tick();
    output_packet = '0;
    tick();
    check_pkt("stall_fourth", input_packet[1], mk(32'h13, 32'h23, CMD_ADD));
    output_packet[1].response = RESP_SUCCESS;
    tick();
    tick();
    output_packet = '0;
    check("stall_restore", 32'(credit_count[1]), 32'd2);
    check("stall_noerr", 32'(credit_error), 32'h0);

    // lane 2: drain credits, fill FIFO, then stream with wrap
    push(2'd2, mk(32'h100, 32'h0, CMD_ADD));
    push(2'd2, mk(32'h101, 32'h0, CMD_ADD));
    tick();
    check("full_cr0", 32'(credit_count[2]), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_p = mk(32'h110 + 32'(k), 32'h210 + 32'(k), CMD_ADD);
      exp_q.push_back(exp_p);
      push(2'd2, exp_p);
    end
    check("full_ready", 32'(req_ready[2]), 32'd0);
    req_valid[2]  = 1'b1;
    req_packet[2] = mk(32'hDEAD, 32'hBEEF, CMD_ADD);
    tick();
    req_valid = '0;
    check("full_reject", 32'(req_ready[2]), 32'd0);
    check_pkt("full_stalled", input_packet[2], NOP_PACKET);

    got  = 0;
    owed = 2;
    more = 0;
    for (int cyc = 0; cyc < 80 && !(got == 12 && owed == 0); cyc++) begin
      if (owed > 0) begin
        output_packet[2].response = RESP_SUCCESS;
        owed--;
      end else begin
        output_packet[2].response = RESP_NONE;
      end
      if (req_ready[2] && more < 8) begin
        exp_p = mk(32'h300 + 32'(more), 32'h400 + 32'(more), CMD_SUB);
        exp_q.push_back(exp_p);
        req_valid[2]  = 1'b1;
        req_packet[2] = exp_p;
        more++;
      end else begin
        req_valid[2] = 1'b0;
      end
      tick();
      if (input_packet[2].command != CMD_NOP) begin
        exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check_pkt($sformatf("order%0d", got), input_packet[2], exp_p);
        got++;
        owed++;
      end
    end
    req_valid = '0;
    output_packet = '0;
    check("wrap_count", 32'(got), 32'd12);
    check("wrap_cr", 32'(credit_count[2]), 32'd2);
    check("wrap_noerr", 32'(credit_error), 32'h0);

    // lane 3: NOP dropped, response coinciding with issue
    push(2'd3, mk(32'hAA, 32'hBB, CMD_NOP));
    push(2'd3, mk(32'h7, 32'h2, CMD_SUB));
    check_pkt("nop_drop", input_packet[3], NOP_PACKET);
    check("nop_cr", 32'(credit_count[3]), 32'd2);
    tick();
    check_pkt("nop_sub", input_packet[3], mk(32'h7, 32'h2, CMD_SUB));
    check("nop_sub_cr", 32'(credit_count[3]), 32'd1);
    push(2'd3, mk(32'h9, 32'h4, CMD_SUB));
    check("simul_pre", 32'(credit_count[3]), 32'd1);
    output_packet[3].response = RESP_SUCCESS;
    tick();
    output_packet = '0;
    check_pkt("simul_issue", input_packet[3], mk(32'h9, 32'h4, CMD_SUB));
    check("simul_cr", 32'(credit_count[3]), 32'd1);
    output_packet[3].response = RESP_INVALID;
    tick();
    output_packet = '0;
    check("simul_ret", 32'(credit_count[3]), 32'd2);

    // lane 0: surplus return
    output_packet[0].response = RESP_OVERFLOW;
    tick();
    output_packet = '0;
    check("err_cr", 32'(credit_count[0]), 32'd2);
    check("err_set", 32'(credit_error), 32'h1);
    repeat (3) tick();
    check("err_sticky", 32'(credit_error), 32'h1);

    // asynchronous reset with lane 1 holding three entries
    for (int k = 0; k < 5; k++) push(2'd1, mk(32'h500 + 32'(k), 32'h0, CMD_ADD));
    check("pre_rst_cr", 32'(credit_count[1]), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    for (int l = 0; l < 4; l++) check_pkt($sformatf("mid_rst_pkt%0d", l), input_packet[l], NOP_PACKET);
    check("mid_rst_cr", 32'(credit_count), 32'h492);
    check("mid_rst_err", 32'(credit_error), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'hF);
    tick();
    tick();
    check_pkt("post_rst_empty", input_packet[1], NOP_PACKET);
    check("post_rst_cr", 32'(credit_count[1]), 32'd2);
    output_packet[1].response = RESP_SUCCESS;
    tick();
    output_packet = '0;
    check("post_rst_err", 32'(credit_error), 32'h2);
    check("post_rst_cr2", 32'(credit_count[1]), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_request_dispatcher.md
Name: alu_request_dispatcher

Overview:
- Upstream stage of the 4-lane ALU. Accepts request packets per lane over a valid/ready handshake and buffers them in a per-lane FIFO.
- Drives the ALU's input_packet array one issued request per lane per cycle, throttled by a per-lane credit counter.
- Credits are returned when the ALU's output_packet carries a response on that lane.

Parameters:
- FIFO_DEPTH, 4, entries per lane request FIFO; power of two, >= 2.
- CREDITS, 2, maximum requests in flight in the ALU per lane; 1..7.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high.
- req_valid, input, 4, per-lane request valid.
- req_ready, output, 4, per-lane FIFO can accept.
- req_packet, input, 4 x input_packet_t, per-lane request (data1, data2, command).
- input_packet, output, 4 x input_packet_t, registered drive to ALU input_packet.
- output_packet, input, 4 x output_packet_t, ALU results; response field used for credit return.
- credit_count, output, 4 x 3, current credits per lane.
- credit_error, output, 4, sticky flag: credit returned while counter already at CREDITS.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; ports are named clock and reset.
- Reset values (while reset is high and immediately after it deasserts):
  - FIFOs empty.
  - input_packet[i] = {data1 0, data2 0, command CMD_NOP}.
  - credit_count = CREDITS.
  - credit_error = 0.
  - req_ready forced 0 while reset is high.
- Reset mid-operation discards all queued and in-flight bookkeeping. Responses arriving after reset are not counted until credits are below CREDITS; otherwise they set credit_error.
- Push: req_valid[i] & req_ready[i] at posedge writes req_packet[i] to the lane FIFO.
  - req_ready[i] = !full[i] & !reset, combinational.
  - No push-when-full; a pop in the same cycle does not make a full FIFO ready.
- Issue, per lane, each posedge, evaluated in this priority:
  - FIFO non-empty, head command != CMD_NOP, credit_count > 0: input_packet[i] <= head; pop; credit decrements.
  - FIFO non-empty, head command == CMD_NOP: pop and drop; input_packet[i] <= NOP with zero data; no credit consumed.
  - Otherwise: input_packet[i] <= NOP with zero data; FIFO unchanged.
- Minimum latency: request accepted at edge N appears on input_packet at edge N+1. An empty FIFO has no bypass path.
- Credit return: output_packet[i].response != RESP_NONE at posedge increments credit_count[i].
  - Return and issue in the same cycle: count unchanged.
  - Return while count == CREDITS with no issue: count holds and credit_error[i] sets. It clears only on reset.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur; occupancy unchanged.
- Pointer wrap: read/write pointers carry one extra bit. Full when addresses match and wrap bits differ; empty when the whole pointers are equal.
- Lanes are fully independent. No cross-lane arbitration or reordering; per-lane order is FIFO order.
- Data fields pass through unmodified (32-bit data1/data2, 2-bit command).

Decomposition:
- Shared package alu_pkg holds:
  - command_t (2-bit): CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_INVALID=3.
  - response_t (2-bit): RESP_NONE=0, RESP_SUCCESS=1, RESP_INVALID=2, RESP_OVERFLOW=3.
  - input_packet_t, output_packet_t.
  - NUM_LANES = 4.
- One sub-module, request_fifo: parameterised synchronous FIFO with async reset, ports push/pop/full/empty/head.
- The top instantiates four request_fifo instances plus per-lane credit logic.

Test Plan:
- Reset: assert reset mid-cycle with lane 1 FIFO holding 3 entries -> req_ready=0 immediately, input_packet all NOP/0, credit_count=2; after release req_ready=4'hF.
- Single issue: lane 1 push {data1 0x0000_0005, data2 0x0000_0003, CMD_ADD} at edge N -> input_packet[1] shows it at edge N+1; credit_count[1]=1 at N+1.
- Credit stall: lane 1 push 4 ADDs back-to-back, no responses -> two issue on consecutive edges; input_packet[1] then NOP; credit_count[1]=0; 2 entries remain. Drive RESP_SUCCESS one cycle -> third ADD issues next edge.
- FIFO full/wrap: lane 2 push 5 requests with credits held at 0 -> req_ready[2]=0 after 4th push; 5th not accepted. Return credits and push 8 more -> all 12 accepted entries emerge in order.
- NOP drop and simultaneous events: lane 3 queue {CMD_NOP, CMD_SUB} -> NOP popped without credit use, SUB issued next edge. Response on the same edge as an issue -> credit_count[3] unchanged.
- Credit error: lane 0 idle at credit_count=2, drive RESP_OVERFLOW -> credit_count[0] stays 2, credit_error[0]=1 and remains set until reset.
